// File: rtl/genius_pkg.sv
// genius_pkg: state encoding, colour codes and LFSR constants for the Genius sprite sequencer.
// ST_ATTRACT exists only when GENIUS_ATTRACT_EN is defined.
package genius_pkg;

    typedef enum logic [2:0] {
        ST_OFF, ST_IDLE, ST_SHOW, ST_GAP, ST_FLASH_ON, ST_FLASH_OFF
`ifdef GENIUS_ATTRACT_EN
        , ST_ATTRACT
`endif
    } state_e;

    typedef enum logic [1:0] {
        COL_BLUE   = 2'd0,
        COL_GREEN  = 2'd1,
        COL_RED    = 2'd2,
        COL_YELLOW = 2'd3
    } colour_e;

    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    localparam int          CNT_W        = 16;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/genius_sprite_sequencer_if.sv
// genius_sprite_sequencer_if: game-side controls and sprite-enable outputs of the sequencer.
interface genius_sprite_sequencer_if;
    logic        VGA_VS;
    logic        PWR_ON;
    logic        PLAY;
    logic [4:0]  LEVEL;
    logic [15:0] SEED;
    logic        RESULT_WIN;
    logic        RESULT_LOSE;
    logic        BLUE_EN, GREEN_EN, RED_EN, YELLOW_EN, LOSE_EN, WIN_EN, PWR_EN;
    logic        BUSY;
    logic [4:0]  STEP_IDX;
    logic        DONE;

    modport master (
        output VGA_VS, PWR_ON, PLAY, LEVEL, SEED, RESULT_WIN, RESULT_LOSE,
        input  BLUE_EN, GREEN_EN, RED_EN, YELLOW_EN, LOSE_EN, WIN_EN, PWR_EN, BUSY, STEP_IDX, DONE
    );

    modport slave (
        input  VGA_VS, PWR_ON, PLAY, LEVEL, SEED, RESULT_WIN, RESULT_LOSE,
        output BLUE_EN, GREEN_EN, RED_EN, YELLOW_EN, LOSE_EN, WIN_EN, PWR_EN, BUSY, STEP_IDX, DONE
    );
endinterface

// File: rtl/genius_lfsr16.sv
// genius_lfsr16: 16-bit Fibonacci LFSR; load takes the seed, advance steps once (both together step the seed).
module genius_lfsr16
    import genius_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        advance,
    output logic [15:0] state
);

    logic [15:0] state_q, state_d, base;

    assign base    = load ? seed : state_q;
    assign state_d = advance ? lfsr_next(base) : base;
    assign state   = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= '0;
        else        state_q <= state_d;
    end

endmodule

// File: rtl/genius_sprite_sequencer.sv
// genius_sprite_sequencer: frame-timed Genius colour playback and WIN/LOSE flashing on registered sprite enables.
// Define GENIUS_ATTRACT_EN to add the idle ATTRACT colour rotation (parameter ATTRACT_FRAMES).
module genius_sprite_sequencer
    import genius_pkg::*;
#(
    parameter int MAX_LEN      = 32,
    parameter int ON_FRAMES    = 30,
    parameter int OFF_FRAMES   = 15,
    parameter int FLASH_FRAMES = 20,
    parameter int FLASH_COUNT  = 3
`ifdef GENIUS_ATTRACT_EN
    , parameter int ATTRACT_FRAMES = 600
`endif
) (
    input  logic CLOCK_50,
    input  logic RESET_N,
    genius_sprite_sequencer_if.slave bus
);

    state_e           state_q, state_d;
    logic             vs_q, tick;
    logic [CNT_W-1:0] cnt_q, cnt_d, pair_q, pair_d;
    logic [4:0]       step_q, step_d, step_idx_q, step_idx_d;
    logic [5:0]       level_q, level_d, level_in;
    logic [15:0]      seed_q, seed_d, lfsr;
    logic             win_q, win_d, load, adv, done_d, rot, idle_like;
    logic             on_exp, off_exp, fl_exp;
    logic [1:0]       acol_q, acol_d, show_col;
    logic [3:0]       col_en_q, col_en_d;
    logic             win_en_q, lose_en_q, pwr_en_q, busy_q, done_q;

    assign tick     = bus.VGA_VS & ~vs_q;
    assign on_exp   = tick && cnt_q == CNT_W'(ON_FRAMES - 1);
    assign off_exp  = tick && cnt_q == CNT_W'(OFF_FRAMES - 1);
    assign fl_exp   = tick && cnt_q == CNT_W'(FLASH_FRAMES - 1);
    assign level_in = (bus.LEVEL == 5'd0) ? 6'd1 :
                      ({1'b0, bus.LEVEL} > 6'(MAX_LEN)) ? 6'(MAX_LEN) : {1'b0, bus.LEVEL};
    assign show_col = 2'(lfsr & 16'h0003);

`ifdef GENIUS_ATTRACT_EN
    logic at_exp;
    assign at_exp    = tick && cnt_q == CNT_W'(ATTRACT_FRAMES - 1);
    assign idle_like = state_q == ST_IDLE || state_q == ST_ATTRACT;
    assign col_en_d  = (state_q == ST_SHOW)    ? 4'b0001 << show_col :
                       (state_q == ST_ATTRACT) ? 4'b0001 << acol_q : 4'b0000;
`else
    assign idle_like = state_q == ST_IDLE;
    assign col_en_d  = (state_q == ST_SHOW) ? 4'b0001 << show_col : 4'b0000;
`endif

    assign step_idx_d = (state_q == ST_SHOW || state_q == ST_GAP) ? step_q : 5'd0;

    genius_lfsr16 u_lfsr (
        .clk     (CLOCK_50),
        .rst_n   (RESET_N),
        .load    (load),
        .seed    (seed_q),
        .advance (adv),
        .state   (lfsr)
    );

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        level_d = level_q;
        seed_d  = seed_q;
        win_d   = win_q;
        pair_d  = pair_q;
        acol_d  = acol_q;
        load    = 1'b0;
        adv     = 1'b0;
        done_d  = 1'b0;
        rot     = 1'b0;
        case (state_q)
            ST_OFF: if (bus.PWR_ON) begin
                seed_d  = (bus.SEED == 16'd0) ? DEFAULT_SEED : bus.SEED;
                state_d = ST_IDLE;
            end
            ST_SHOW: if (on_exp) state_d = ST_GAP;
            ST_GAP: if (off_exp) begin
                if ({1'b0, step_q} == level_q - 6'd1) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    step_d  = step_q + 5'd1;
                    adv     = 1'b1;
                    state_d = ST_SHOW;
                end
            end
            ST_FLASH_ON: if (fl_exp) state_d = ST_FLASH_OFF;
            ST_FLASH_OFF: if (fl_exp) begin
                if (pair_q == CNT_W'(FLASH_COUNT - 1)) state_d = ST_IDLE;
                else begin
                    pair_d  = pair_q + CNT_W'(1);
                    state_d = ST_FLASH_ON;
                end
            end
`ifdef GENIUS_ATTRACT_EN
            ST_ATTRACT: if (on_exp) begin
                acol_d = acol_q + 2'd1;
                rot    = 1'b1;
            end
`endif
            default: ;
        endcase
        // Results outrank PLAY, LOSE outranks WIN; anything outside IDLE/ATTRACT is dropped.
        if (idle_like) begin
            if (bus.RESULT_LOSE || bus.RESULT_WIN) begin
                win_d   = ~bus.RESULT_LOSE;
                pair_d  = '0;
                state_d = ST_FLASH_ON;
            end else if (bus.PLAY) begin
                load    = 1'b1;
                adv     = 1'b1;
                step_d  = 5'd0;
                level_d = level_in;
                state_d = ST_SHOW;
            end
`ifdef GENIUS_ATTRACT_EN
            else if (state_q == ST_IDLE && at_exp) begin
                acol_d  = COL_BLUE;
                state_d = ST_ATTRACT;
            end
`endif
        end
        if (!bus.PWR_ON) begin
            state_d = ST_OFF;
            done_d  = 1'b0;
        end
        cnt_d = (state_d != state_q || rot) ? '0 : tick ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_OFF;
            vs_q       <= 1'b0;
            cnt_q      <= '0;
            pair_q     <= '0;
            step_q     <= '0;
            level_q    <= '0;
            seed_q     <= '0;
            win_q      <= 1'b0;
            acol_q     <= '0;
            col_en_q   <= '0;
            win_en_q   <= 1'b0;
            lose_en_q  <= 1'b0;
            pwr_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            step_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            vs_q       <= bus.VGA_VS;
            cnt_q      <= cnt_d;
            pair_q     <= pair_d;
            step_q     <= step_d;
            level_q    <= level_d;
            seed_q     <= seed_d;
            win_q      <= win_d;
            acol_q     <= acol_d;
            col_en_q   <= col_en_d;
            win_en_q   <= state_q == ST_FLASH_ON && win_q;
            lose_en_q  <= state_q == ST_FLASH_ON && !win_q;
            pwr_en_q   <= state_q != ST_OFF;
            busy_q     <= state_q != ST_OFF && !idle_like;
            done_q     <= done_d;
            step_idx_q <= step_idx_d;
        end
    end

    assign bus.BLUE_EN   = col_en_q[0];
    assign bus.GREEN_EN  = col_en_q[1];
    assign bus.RED_EN    = col_en_q[2];
    assign bus.YELLOW_EN = col_en_q[3];
    assign bus.WIN_EN    = win_en_q;
    assign bus.LOSE_EN   = lose_en_q;
    assign bus.PWR_EN    = pwr_en_q;
    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;
    assign bus.STEP_IDX  = step_idx_q;

endmodule

// File: tb/tb_genius_sprite_sequencer.sv
// tb_genius_sprite_sequencer: observes sprite-enable pulses over time and compares them with a frame/LFSR reference model.
// Frames are 20 clocks; ON=2, OFF=1, FLASH=2 frames, COUNT=2 pairs (ATTRACT_FRAMES=5 with GENIUS_ATTRACT_EN).
module tb_genius_sprite_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   obs_col[$];
    int   obs_len[$];
    int   gap_len[$];
    int   saved[$];

    genius_sprite_sequencer_if bus();

    genius_sprite_sequencer #(
        .MAX_LEN      (32),
        .ON_FRAMES    (2),
        .OFF_FRAMES   (1),
        .FLASH_FRAMES (2),
        .FLASH_COUNT  (2)
`ifdef GENIUS_ATTRACT_EN
        , .ATTRACT_FRAMES (5)
`endif
    ) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    initial begin
        bus.VGA_VS = 1'b0;
        forever begin
            repeat (19) @(negedge clk);
            bus.VGA_VS = 1'b1;
            @(negedge clk);
            bus.VGA_VS = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [3:0] colours();
        return {bus.YELLOW_EN, bus.RED_EN, bus.GREEN_EN, bus.BLUE_EN};
    endfunction

    function automatic logic [6:0] enables();
        return {colours(), bus.LOSE_EN, bus.WIN_EN, bus.PWR_EN};
    endfunction

    function automatic int col_idx(input logic [3:0] v);
        case (v)
            4'b0001: return 0;
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic power_cycle(input logic [15:0] seed);
        @(negedge clk);
        bus.PWR_ON = 1'b0;
        repeat (3) @(negedge clk);
        bus.SEED   = seed;
        bus.PWR_ON = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Records every colour pulse (colour, length, gap) until DONE, then scores against the model.
    task automatic run_play(input logic [4:0] lvl, input int nexp, input logic [15:0] seed_eff, input string tag);
        logic [15:0] s;
        logic [3:0]  v, pv;
        int run, gap, budget, done_cnt, bad_hot, bad_step, bad_busy, l0;
        obs_col.delete(); obs_len.delete(); gap_len.delete();
        run = 0; gap = 0; done_cnt = 0; bad_hot = 0; bad_step = 0; bad_busy = 0; pv = '0;
        budget = nexp * 80 + 200;
        @(negedge clk);
        bus.LEVEL = lvl;
        bus.PLAY  = 1'b1;
        @(negedge clk);
        bus.PLAY  = 1'b0;
        while (done_cnt == 0 && budget > 0) begin
            v = colours();
            if (v != 0 && col_idx(v) < 0) bad_hot++;
            if (v != 0) begin
                if (pv == 0) begin
                    obs_col.push_back(col_idx(v));
                    if (obs_col.size() > 1) gap_len.push_back(gap);
                    run = 0;
                    if (int'(bus.STEP_IDX) != obs_col.size() - 1) bad_step++;
                    if (!bus.BUSY || !bus.PWR_EN) bad_busy++;
                end
                run++;
            end else begin
                if (pv != 0) begin
                    obs_len.push_back(run);
                    gap = 0;
                end
                gap++;
            end
            if (bus.DONE) done_cnt++;
            pv = v;
            budget--;
            @(negedge clk);
        end
        check({tag, "_done_seen"}, done_cnt, 1);
        repeat (5) begin
            if (bus.DONE) done_cnt++;
            @(negedge clk);
        end
        check({tag, "_done_once"}, done_cnt, 1);
        check({tag, "_busy_after"}, bus.BUSY, 1'b0);
        check({tag, "_pulses"}, obs_col.size(), nexp);
        check({tag, "_onehot"}, bad_hot, 0);
        check({tag, "_step_idx"}, bad_step, 0);
        check({tag, "_busy_pwr"}, bad_busy, 0);
        s = seed_eff;
        for (int i = 0; i < nexp; i++) begin
            s = ref_next(s);
            check($sformatf("%s_col%0d", tag, i), (i < obs_col.size()) ? obs_col[i] : -2, int'(s[1:0]));
        end
        l0 = (obs_len.size() > 0) ? obs_len[0] : 0;
        check({tag, "_len0_range"}, (l0 > 20 && l0 <= 40), 1'b1);
        for (int i = 1; i < obs_len.size(); i++)
            check($sformatf("%s_len%0d", tag, i), obs_len[i], 40);
        for (int i = 0; i < gap_len.size(); i++)
            check($sformatf("%s_gap%0d", tag, i), gap_len[i], 20);
    endtask

    // Issues a result (optionally with PLAY alongside) and scores the flash pattern of the expected sprite.
    task automatic run_flash(input logic w, input logic l, input logic p, input logic exp_win, input string tag);
        int lens[$];
        int gaps[$];
        int run, gap, other, colour;
        logic t, pt;
        run = 0; gap = 0; other = 0; colour = 0; pt = 1'b0;
        @(negedge clk);
        bus.RESULT_WIN  = w;
        bus.RESULT_LOSE = l;
        bus.PLAY        = p;
        bus.LEVEL       = 5'd2;
        @(negedge clk);
        bus.RESULT_WIN  = 1'b0;
        bus.RESULT_LOSE = 1'b0;
        bus.PLAY        = 1'b0;
        for (int c = 0; c < 200; c++) begin
            bus.PLAY = (c == 60);
            t = exp_win ? bus.WIN_EN : bus.LOSE_EN;
            if (exp_win ? bus.LOSE_EN : bus.WIN_EN) other++;
            if (colours() != 0) colour++;
            if (t) begin
                if (!pt && lens.size() > 0) gaps.push_back(gap);
                run = pt ? run + 1 : 1;
            end else begin
                if (pt) begin
                    lens.push_back(run);
                    gap = 0;
                end
                gap++;
            end
            pt = t;
            @(negedge clk);
        end
        bus.PLAY = 1'b0;
        check({tag, "_flashes"}, lens.size(), 2);
        check({tag, "_len0_range"}, (lens.size() > 0 && lens[0] > 20 && lens[0] <= 40), 1'b1);
        check({tag, "_len1"}, (lens.size() > 1) ? lens[1] : 0, 40);
        check({tag, "_gap"}, (gaps.size() > 0) ? gaps[0] : 0, 40);
        check({tag, "_other_sprite"}, other, 0);
        check({tag, "_no_colour"}, colour, 0);
        check({tag, "_idle_after"}, {bus.BUSY, bus.PWR_EN}, 2'b01);
    endtask

    initial begin
        int found, done_cnt, lit;
        bus.PWR_ON = 1'b1; bus.PLAY = 1'b0; bus.LEVEL = 5'd3; bus.SEED = 16'h0001;
        bus.RESULT_WIN = 1'b0; bus.RESULT_LOSE = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {enables(), bus.BUSY, bus.DONE, bus.STEP_IDX}, 14'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("power_on_pwr_en", enables(), 7'b0000001);
        check("power_on_busy", bus.BUSY, 1'b0);

        run_play(5'd3, 3, 16'h0001, "lv3");
        saved = obs_col;
        run_play(5'd4, 4, 16'h0001, "lv4");
        for (int i = 0; i < 3; i++)
            check($sformatf("prefix%0d", i), (i < obs_col.size()) ? obs_col[i] : -2, (i < saved.size()) ? saved[i] : -3);

        run_flash(1'b1, 1'b0, 1'b0, 1'b1, "win");
        run_flash(1'b1, 1'b1, 1'b1, 1'b0, "both");

        // Abort during step 1 of playback.
        @(negedge clk);
        bus.LEVEL = 5'd3;
        bus.PLAY  = 1'b1;
        @(negedge clk);
        bus.PLAY  = 1'b0;
        found = 0;
        for (int c = 0; c < 400 && found == 0; c++) begin
            @(negedge clk);
            if (bus.STEP_IDX == 5'd1 && colours() != 0) found = 1;
        end
        check("abort_reach_step1", found, 1);
        bus.PWR_ON = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_enables_off", enables(), 7'd0);
        done_cnt = 0; lit = 0;
        repeat (150) begin
            @(negedge clk);
            if (bus.DONE) done_cnt++;
            if (enables() != 0 || bus.BUSY) lit++;
        end
        check("abort_no_done", done_cnt, 0);
        check("abort_stays_off", lit, 0);
        bus.PWR_ON = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_repower", {enables(), bus.BUSY, bus.STEP_IDX}, {7'b0000001, 1'b0, 5'd0});

        run_play(5'd0, 1, 16'h0001, "lv0");
        run_play(5'd31, 31, 16'h0001, "lv31");

        power_cycle(16'h0000);
        run_play(5'd3, 3, 16'hACE1, "seed0");
        saved = obs_col;
        power_cycle(16'hACE1);
        run_play(5'd3, 3, 16'hACE1, "seedace1");
        for (int i = 0; i < 3; i++)
            check($sformatf("seed0_eq_ace1_%0d", i), (i < obs_col.size()) ? obs_col[i] : -2, (i < saved.size()) ? saved[i] : -3);

`ifdef GENIUS_ATTRACT_EN
        found = 0;
        for (int c = 0; c < 200 && found == 0; c++) begin
            @(negedge clk);
            if (colours() != 0) found = 1;
        end
        check("attract_start", found, 1);
        check("attract_first_blue", col_idx(colours()), 0);
        check("attract_not_busy", bus.BUSY, 1'b0);
        found = 0;
        for (int c = 0; c < 80 && found == 0; c++) begin
            @(negedge clk);
            if (colours() != 4'b0001) found = 1;
        end
        check("attract_then_green", col_idx(colours()), 1);
        bus.LEVEL = 5'd1;
        bus.PLAY  = 1'b1;
        @(negedge clk);
        bus.PLAY  = 1'b0;
        @(negedge clk);
        check("attract_play_busy", bus.BUSY, 1'b1);
        found = 0;
        for (int c = 0; c < 200 && found == 0; c++) begin
            @(negedge clk);
            if (bus.DONE) found = 1;
        end
        check("attract_play_done", found, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
